// File: rtl/imm_ext_pkg.sv
// Shared types and the immediate-extension function for imm_ext_pipe.
// Both the RTL and reference models use ext_calc so the mode semantics live in one place.
package imm_ext_pkg;

    localparam int IMM_MODE_W = 3;
    localparam int EXT_MAX_W  = 64;

    typedef enum logic [IMM_MODE_W-1:0] {
        IMM_ZERO   = 3'd0,
        IMM_SIGN   = 3'd1,
        IMM_UPPER  = 3'd2,
        IMM_BRANCH = 3'd3,
        IMM_SHAMT  = 3'd4
    } imm_mode_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    // Returns {err, value}; value is EXT_MAX_W wide and callers truncate to their OUT_W.
    function automatic logic [EXT_MAX_W:0] ext_calc(
        input logic [EXT_MAX_W-1:0]  imm,
        input logic [IMM_MODE_W-1:0] mode,
        input int                    in_w,
        input int                    br_shift
    );
        logic [EXT_MAX_W-1:0] mask;
        logic [EXT_MAX_W-1:0] zext;
        logic [EXT_MAX_W-1:0] sext;
        logic [EXT_MAX_W:0]   res;
        mask = (EXT_MAX_W'(1) << in_w) - EXT_MAX_W'(1);
        zext = imm & mask;
        sext = (|(imm & (EXT_MAX_W'(1) << (in_w - 1)))) ? (zext | ~mask) : zext;
        res  = '0;
        case (mode)
            IMM_ZERO:   res[EXT_MAX_W-1:0] = zext;
            IMM_SIGN:   res[EXT_MAX_W-1:0] = sext;
            IMM_UPPER:  res[EXT_MAX_W-1:0] = zext << in_w;
            IMM_BRANCH: res[EXT_MAX_W-1:0] = sext << br_shift;
            IMM_SHAMT:  res[4:0]           = imm[4:0];
            default:    res[EXT_MAX_W]     = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; in_ready and out_* come straight from flops,
// so there is no combinational path between out_ready and in_ready.
module imm_skid_buf
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = 33
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    buf_state_e        state_q, state_d;
    logic [DATA_W-1:0] main_q, skid_q;
    logic              in_fire, out_fire;
    logic              load_main, load_skid, promote;

    assign in_ready  = (state_q != BUF_FULL);
    assign out_valid = (state_q != BUF_EMPTY);
    assign out_data  = main_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        promote   = 1'b0;
        case (state_q)
            BUF_EMPTY: if (in_fire) begin
                state_d   = BUF_ONE;
                load_main = 1'b1;
            end
            BUF_ONE: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    state_d   = BUF_FULL;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_d   = BUF_EMPTY;
                end
            end
            BUF_FULL: if (out_fire) begin
                state_d = BUF_ONE;
                promote = 1'b1;
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main)    main_q <= in_data;
            else if (promote) main_q <= skid_q;
            if (load_skid)    skid_q <= in_data;
        end
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender with valid/ready skid buffering.
// Define IMM_EXT_STATS_EN to add transfer/error/stall statistics counters.
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_imm,
    input  logic [IMM_MODE_W-1:0] in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_imm,
    output logic                  out_err
`ifdef IMM_EXT_STATS_EN
    ,
    output logic [31:0]           stat_xfer,
    output logic [15:0]           stat_err,
    output logic [31:0]           stat_stall
`endif
);

    if (IN_W < 6) begin : g_bad_in_w
        $error("imm_ext_pipe: IN_W must be >= 6");
    end
    if (OUT_W < 2 * IN_W || OUT_W > EXT_MAX_W) begin : g_bad_out_w
        $error("imm_ext_pipe: OUT_W must be >= 2*IN_W and <= 64");
    end
    if (BR_SHIFT >= OUT_W - IN_W) begin : g_bad_br_shift
        $error("imm_ext_pipe: BR_SHIFT must be < OUT_W-IN_W");
    end

    logic [EXT_MAX_W:0] ext;
    logic               ext_unused;
    logic [OUT_W:0]     in_data, out_data;

    assign ext        = ext_calc(EXT_MAX_W'(in_imm), in_mode, IN_W, BR_SHIFT);
    assign ext_unused = ^ext;
    assign in_data    = {ext[EXT_MAX_W], ext[OUT_W-1:0]};

    imm_skid_buf #(.DATA_W(OUT_W + 1)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    assign out_err = out_data[OUT_W];
    assign out_imm = out_data[OUT_W-1:0];

`ifdef IMM_EXT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_xfer  <= '0;
            stat_err   <= '0;
            stat_stall <= '0;
        end else begin
            if (out_valid && out_ready)            stat_xfer  <= stat_xfer + 32'd1;
            if (out_valid && out_ready && out_err) stat_err   <= stat_err + 16'd1;
            if (out_valid && !out_ready)           stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: driver pushes hand-computed results, monitor pops on output fire.
// Stats counters are checked when IMM_EXT_STATS_EN is defined.
module tb_imm_ext_pipe;
    import imm_ext_pkg::*;

    typedef struct packed {
        logic [31:0] imm;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic [15:0] imm;
        logic [2:0]  mode;
        logic [31:0] eimm;
        logic        eerr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [2:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic        out_err;
`ifdef IMM_EXT_STATS_EN
    logic [31:0] stat_xfer;
    logic [15:0] stat_err;
    logic [31:0] stat_stall;
`endif

    int   nvec = 0;
    int   nerr = 0;
    exp_t sb[$];
    vec_t tbl[10];

    always #5 clk = ~clk;

    imm_ext_pipe #(.IN_W(16), .OUT_W(32), .BR_SHIFT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_err   (out_err)
`ifdef IMM_EXT_STATS_EN
        ,
        .stat_xfer (stat_xfer),
        .stat_err  (stat_err),
        .stat_stall(stat_stall)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the request was accepted.
    task automatic send(input logic [15:0] imm, input logic [2:0] mode,
                        input logic [31:0] eimm, input logic eerr);
        int waits = 0;
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        while (!in_ready && waits < 50) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!in_ready) begin
            check("send_timeout_in_ready", 32'(in_ready), 32'd1);
        end else begin
            sb.push_back('{eimm, eerr});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_imm   = 16'($urandom);
        in_mode  = 3'($urandom);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Monitor: pop on output fire, and require held data while stalled.
    initial begin : monitor
        logic        prev_stall;
        logic [32:0] prev;
        exp_t        e;
        prev_stall = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (out_valid && prev_stall)
                    check("stall_stable", {out_imm[30:0], out_err}, {prev[31:1], prev[0]});
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output_count", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("out_imm", out_imm, e.imm);
                        check("out_err", 32'(out_err), 32'(e.err));
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev       = {out_imm, out_err};
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        tbl[0] = '{16'h0001, 3'd0, 32'h00000001, 1'b0};
        tbl[1] = '{16'hFFFE, 3'd1, 32'hFFFFFFFE, 1'b0};
        tbl[2] = '{16'h00A5, 3'd2, 32'h00A50000, 1'b0};
        tbl[3] = '{16'h8000, 3'd3, 32'hFFFE0000, 1'b0};
        tbl[4] = '{16'hFFE3, 3'd4, 32'h00000003, 1'b0};
        tbl[5] = '{16'h1111, 3'd5, 32'h00000000, 1'b1};
        tbl[6] = '{16'h7FFF, 3'd1, 32'h00007FFF, 1'b0};
        tbl[7] = '{16'hFFFF, 3'd7, 32'h00000000, 1'b1};
        tbl[8] = '{16'h0003, 3'd3, 32'h0000000C, 1'b0};
        tbl[9] = '{16'hFFFF, 3'd0, 32'h0000FFFF, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_imm    = '0;
        in_mode   = '0;
        out_ready = 1'b1;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_imm",   out_imm,        32'd0);
        check("rst_out_err",   32'(out_err),   32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single SIGN request, one-cycle latency
        send(16'h8004, IMM_SIGN, 32'hFFFF8004, 1'b0);
        @(negedge clk);
        check("single_valid_n1", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("single_valid_n2", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // back-to-back stream
        send(16'h8004, IMM_ZERO,   32'h00008004, 1'b0);
        send(16'h1234, IMM_UPPER,  32'h12340000, 1'b0);
        send(16'hFFFF, IMM_BRANCH, 32'hFFFFFFFC, 1'b0);
        send(16'h00FF, IMM_SHAMT,  32'h0000001F, 1'b0);
        repeat (3) @(posedge clk); #1;

        // backpressure: A in main, B in skid, C held off
        out_ready = 1'b0;
        send(16'h7FFF, IMM_SIGN,   32'h00007FFF, 1'b0);
        send(16'h0001, IMM_BRANCH, 32'h00000004, 1'b0);
        fork
            send(16'hFFFF, IMM_UPPER, 32'hFFFF0000, 1'b0);
            begin
                @(negedge clk);
                check("bp_in_ready_low", 32'(in_ready), 32'd0);
                check("bp_main_is_a",    out_imm,       32'h00007FFF);
                @(negedge clk);
                check("bp_in_ready_hold", 32'(in_ready), 32'd0);
                @(posedge clk); #1;
                out_ready = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("bp_no_gap", 32'(out_valid), 32'd1);
                end
            end
        join
        repeat (3) @(posedge clk); #1;

        // illegal mode, then a legal request clears err
        send(16'hABCD, 3'd6,     32'h00000000, 1'b1);
        send(16'h8004, IMM_SIGN, 32'hFFFF8004, 1'b0);
        repeat (3) @(posedge clk); #1;

        // reset while FULL drops everything
        out_ready = 1'b0;
        send(16'h1234, IMM_ZERO, 32'h00001234, 1'b0);
        send(16'h5678, IMM_ZERO, 32'h00005678, 1'b0);
        check("full_in_ready_low", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        sb.delete();
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(16'h0042, IMM_SIGN, 32'h00000042, 1'b0);
        repeat (3) @(posedge clk); #1;

        // table run with a 5-cycle stall on entry 4; counters start from a fresh reset
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                repeat (2) @(posedge clk); #1;
                out_ready = 1'b0;
            end
            send(tbl[i].imm, tbl[i].mode, tbl[i].eimm, tbl[i].eerr);
            if (i == 4) begin
                repeat (5) @(posedge clk); #1;
                out_ready = 1'b1;
            end
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
`ifdef IMM_EXT_STATS_EN
        check("stat_xfer",  stat_xfer,         32'd10);
        check("stat_err",   32'(stat_err),     32'd2);
        check("stat_stall", stat_stall,        32'd5);
`endif
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
